channel_endpoint: RTL and testbench
===================================

# channel_endpoint

Channel-side peer of the FCP channel interface: terminates one numbered channel (CH_ID) and converts the shared broadcast/muxed channel bus into two private, frame-buffered streams for user logic. Receive path: frames broadcast by the channel interface are accepted only while this channel's write enable is set. They are stored in a frame FIFO and released to the user only when complete. Transmit path: user frames are stored whole and offered back to the channel interface only while this channel's read enable is set.

## Interface
- ADDR_W, 4: log2 of FIFO depth per direction (DEPTH = 2^ADDR_W entries, one byte per entry)
- CH_ID, 1: channel number 1..15; documentation and assertion use only
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- ch_rx_sof / ch_rx_eof / ch_rx_src_rdy  in  1  from channel interface chN_out_* (broadcast to all channels)
- ch_rx_data  in  8  from chN_out_data
- ch_rx_dst_rdy  out  1  to chN_out_dst_rdy
- ch_wen  in  1  chN_wen
- ch_tx_sof / ch_tx_eof / ch_tx_src_rdy  out  1  to chN_in_*
- ch_tx_data  out  8  to chN_in_data
- ch_tx_dst_rdy  in  1  chN_in_dst_rdy (shared, not gated by ren)
- ch_ren  in  1  chN_ren
- usr_rx_sof / usr_rx_eof / usr_rx_src_rdy  out  1;  usr_rx_data  out  8;  usr_rx_dst_rdy  in  1
- usr_tx_sof / usr_tx_eof / usr_tx_src_rdy  in  1;  usr_tx_data  in  8;  usr_tx_dst_rdy  out  1
- rx_drop_cnt  out  8  saturating count of dropped rx frames
- tx_drop_cnt  out  8  saturating count of dropped (oversize) tx frames

## Operation
- Beat definition: a beat transfers on a rising edge when src_rdy & dst_rdy.
- Rx write qualifier: wen & ch_rx_src_rdy & ch_rx_dst_rdy. The src_rdy and dst_rdy signals are shared across all channels, so wen gating is mandatory.
- Tx pop qualifier: ch_ren & ch_tx_src_rdy & ch_tx_dst_rdy. ch_tx_dst_rdy is not gated by ren upstream, so gating by ren here is mandatory.
- ch_tx_src_rdy is driven as "committed frame data available", independent of ren. The upstream mux masks it.
- Each FIFO entry is {sof, eof, data[7:0]} (10 bits).
- Write pointers:
  - wr_ptr is the working pointer; wr_commit is the committed pointer.
  - The read side sees only entries below wr_commit.
  - Pointers are ADDR_W+1 bits and wrap modulo 2·DEPTH.
  - full = (wr_ptr − rd_ptr) == DEPTH; empty = (rd_ptr == wr_commit).
- Write FSM states: IDLE, IN_FRAME, DISCARD.
  - IDLE: a beat without sof is discarded silently. A sof beat is written and the FSM moves to IN_FRAME; a sof&eof beat is written and committed, and the FSM stays in IDLE.
  - IN_FRAME, beat with eof: write the beat, set wr_commit = wr_ptr+1, go to IDLE.
  - IN_FRAME, beat with sof (truncated previous frame): rewind wr_ptr to wr_commit, increment the drop counter, and write the new beat as a frame start.
  - IN_FRAME, full:
    - DROP_ON_FULL=1 (rx instance): rewind wr_ptr to wr_commit, increment the drop counter, go to DISCARD.
    - DROP_ON_FULL=0 (tx instance): dst_rdy = !full, i.e. backpressure. Exception: if full and empty both hold, the frame can never fit, so apply the drop behaviour.
  - DISCARD: dst_rdy = 1, beats are consumed and not written. On eof go to IDLE. On sof, behave as IDLE with a sof beat.
- Rx dst_rdy is 1 whenever out of reset.
- Read side: first-word-fall-through. src_rdy = !empty; sof, eof and data come combinationally from mem[rd_ptr]. rd_ptr increments on the pop qualifier.
- Drop counters saturate at 8'hFF.

## Timing
- Reset values:
  - all src_rdy = 0, all dst_rdy = 0, drop counters = 0;
  - pointers = 0, FSM = IDLE;
  - FIFO contents are don't-care.
- Commit to visibility: the eof beat is written at edge N, and the read side asserts src_rdy in cycle N+1. Minimum rx latency is 1 cycle after eof.
- Simultaneous read and write in the same cycle are both honoured. full is evaluated before the write; a pop in the same cycle does not free space for that write.
- Full throughput: one beat per cycle per direction.
- ren deasserting mid-frame: the tx output holds its current entry, no pop occurs, and the frame resumes when ren returns.
- Reset asserted mid-frame: all frames are lost, outputs go to reset values immediately (asynchronously), and no partial frame is emitted after reset.

## Structure
- Shared include chan_defs:
  - ENTRY_W = 10;
  - SOF_BIT = 9, EOF_BIT = 8;
  - write-FSM state encodings.
- Sub-module chan_frame_fifo (parameters ADDR_W, DROP_ON_FULL; holds the write FSM, commit/rewind, FWFT read and drop counter).
- Instantiated twice: rx with DROP_ON_FULL=1, tx with DROP_ON_FULL=0.
- The top level adds only the wen/ren qualification.

## Test plan
- Basic rx frame: wen=1, 5-byte frame 0x11..0x15 → usr_rx_src_rdy rises 1 cycle after the eof beat, bytes delivered in order, sof on 0x11, eof on 0x15.
- wen filtering: wen=0 during an identical frame → nothing stored, usr_rx_src_rdy stays 0, rx_drop_cnt=0.
- Rx overflow (ADDR_W=4): 20-byte frame with user stalled → frame dropped, rx_drop_cnt=1. A following 3-byte frame is delivered intact.
- Tx ren gating: user writes a 4-byte frame, ch_tx_dst_rdy=1, ren toggles 1,0,0,1… → exactly 4 pops, occurring only on ren=1 cycles, with no duplicated or skipped byte.
- Tx backpressure vs oversize drop:
  - 16-byte frame behind a pending committed frame → usr_tx_dst_rdy=0 until a pop.
  - 17-byte frame into an empty FIFO → tx_drop_cnt=1, usr_tx_dst_rdy stays 1 through eof.
- Truncation and reset: sof arriving without a prior eof → previous partial frame dropped, drop_cnt+1, new frame stored. rst_n pulled low mid-frame → all src_rdy=0 immediately, FIFO empty after release.

Source files
------------

// File: rtl/channel_endpoint_pkg.sv
// Shared definitions for the channel endpoint: FIFO entry layout, write-FSM
// state encodings and a saturating counter helper.
package channel_endpoint_pkg;

  localparam int ENTRY_W = 10;
  localparam int SOF_BIT = 9;
  localparam int EOF_BIT = 8;

  localparam logic [1:0] WR_IDLE     = 2'd0;
  localparam logic [1:0] WR_IN_FRAME = 2'd1;
  localparam logic [1:0] WR_DISCARD  = 2'd2;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/chan_frame_fifo.sv
// Frame-buffered FIFO: frames become visible to the read side only once their
// eof beat is written. Partial frames are rewound on truncation or overflow.
//
//   state        | meaning
//   WR_IDLE      | between frames, waiting for a sof beat
//   WR_IN_FRAME  | storing beats of an uncommitted frame
//   WR_DISCARD   | frame was dropped, swallowing beats until eof
module chan_frame_fifo
  import channel_endpoint_pkg::*;
#(
  parameter int ADDR_W       = 4,
  parameter bit DROP_ON_FULL = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       wr_valid,
  input  logic       wr_sof,
  input  logic       wr_eof,
  input  logic [7:0] wr_data,
  output logic       wr_ready,
  output logic       rd_valid,
  output logic       rd_sof,
  output logic       rd_eof,
  output logic [7:0] rd_data,
  input  logic       rd_pop,
  output logic [7:0] drop_cnt
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W:0] DEPTH_P = {1'b1, {ADDR_W{1'b0}}};

  logic [ENTRY_W-1:0] mem [DEPTH];
  logic [ENTRY_W-1:0] rd_entry;

  logic [ADDR_W:0]   wr_ptr, wr_commit, rd_ptr;
  logic [ADDR_W:0]   wr_ptr_d, wr_commit_d;
  logic [ADDR_W-1:0] waddr;
  logic [1:0]        state, state_d;
  logic              live;
  logic              full, full_c, empty, beat, pop, we, drop;

  // full uses the working pointer; full_c asks whether committed data alone fills the FIFO
  assign full  = (wr_ptr - rd_ptr) == DEPTH_P;
  assign full_c = (wr_commit - rd_ptr) == DEPTH_P;
  assign empty = (rd_ptr == wr_commit);

  // full & empty together means the frame in progress can never fit: accept and drop it
  assign wr_ready = live & (DROP_ON_FULL | ~full | empty | (state == WR_DISCARD));
  assign beat     = wr_valid & wr_ready;

  assign rd_entry = mem[rd_ptr[ADDR_W-1:0]];
  assign rd_valid = ~empty;
  assign rd_sof   = rd_entry[SOF_BIT];
  assign rd_eof   = rd_entry[EOF_BIT];
  assign rd_data  = rd_entry[7:0];
  assign pop      = rd_pop & ~empty;

  // Write FSM: decide next pointers, state, memory write and drop event
  always_comb begin
    state_d     = state;
    wr_ptr_d    = wr_ptr;
    wr_commit_d = wr_commit;
    waddr       = wr_ptr[ADDR_W-1:0];
    we          = 1'b0;
    drop        = 1'b0;
    if (beat) begin
      if (wr_sof) begin
        // a sof always restarts from the committed pointer, discarding any partial frame
        if (full_c) begin
          drop     = 1'b1;
          wr_ptr_d = wr_commit;
          state_d  = wr_eof ? WR_IDLE : WR_DISCARD;
        end else begin
          drop     = (state == WR_IN_FRAME);
          we       = 1'b1;
          waddr    = wr_commit[ADDR_W-1:0];
          wr_ptr_d = wr_commit + 1'b1;
          if (wr_eof) begin
            wr_commit_d = wr_commit + 1'b1;
            state_d     = WR_IDLE;
          end else begin
            state_d = WR_IN_FRAME;
          end
        end
      end else begin
        case (state)
          WR_IN_FRAME: begin
            if (full) begin
              drop     = 1'b1;
              wr_ptr_d = wr_commit;
              state_d  = wr_eof ? WR_IDLE : WR_DISCARD;
            end else begin
              we       = 1'b1;
              wr_ptr_d = wr_ptr + 1'b1;
              if (wr_eof) begin
                wr_commit_d = wr_ptr + 1'b1;
                state_d     = WR_IDLE;
              end
            end
          end
          WR_DISCARD: begin
            if (wr_eof) state_d = WR_IDLE;
          end
          default: ;
        endcase
      end
    end
  end

  // Pointer, state and drop-counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      live      <= 1'b0;
      state     <= WR_IDLE;
      wr_ptr    <= '0;
      wr_commit <= '0;
      rd_ptr    <= '0;
      drop_cnt  <= '0;
    end else begin
      live      <= 1'b1;
      state     <= state_d;
      wr_ptr    <= wr_ptr_d;
      wr_commit <= wr_commit_d;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      if (drop) drop_cnt <= sat_inc8(drop_cnt);
    end
  end

  // Storage array; contents are don't-care after reset
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= {wr_sof, wr_eof, wr_data};
  end

endmodule

// File: rtl/channel_endpoint.sv
// Channel endpoint: terminates one channel of the shared channel bus. Rx beats
// are taken only while wen is set; tx pops happen only while ren is set.
module channel_endpoint
  import channel_endpoint_pkg::*;
#(
  parameter int ADDR_W = 4,
  parameter int CH_ID  = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ch_rx_sof,
  input  logic       ch_rx_eof,
  input  logic       ch_rx_src_rdy,
  input  logic [7:0] ch_rx_data,
  output logic       ch_rx_dst_rdy,
  input  logic       ch_wen,
  output logic       ch_tx_sof,
  output logic       ch_tx_eof,
  output logic       ch_tx_src_rdy,
  output logic [7:0] ch_tx_data,
  input  logic       ch_tx_dst_rdy,
  input  logic       ch_ren,
  output logic       usr_rx_sof,
  output logic       usr_rx_eof,
  output logic       usr_rx_src_rdy,
  output logic [7:0] usr_rx_data,
  input  logic       usr_rx_dst_rdy,
  input  logic       usr_tx_sof,
  input  logic       usr_tx_eof,
  input  logic       usr_tx_src_rdy,
  input  logic [7:0] usr_tx_data,
  output logic       usr_tx_dst_rdy,
  output logic [7:0] rx_drop_cnt,
  output logic [7:0] tx_drop_cnt
);

  if (CH_ID < 1 || CH_ID > 15) begin : g_bad_ch_id
    $error("channel_endpoint: CH_ID must be in 1..15");
  end

  // src/dst_rdy on the channel bus are shared by all channels, hence wen/ren gating
  chan_frame_fifo #(.ADDR_W(ADDR_W), .DROP_ON_FULL(1'b1)) u_rx (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_valid (ch_wen & ch_rx_src_rdy),
    .wr_sof   (ch_rx_sof),
    .wr_eof   (ch_rx_eof),
    .wr_data  (ch_rx_data),
    .wr_ready (ch_rx_dst_rdy),
    .rd_valid (usr_rx_src_rdy),
    .rd_sof   (usr_rx_sof),
    .rd_eof   (usr_rx_eof),
    .rd_data  (usr_rx_data),
    .rd_pop   (usr_rx_dst_rdy),
    .drop_cnt (rx_drop_cnt)
  );

  chan_frame_fifo #(.ADDR_W(ADDR_W), .DROP_ON_FULL(1'b0)) u_tx (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_valid (usr_tx_src_rdy),
    .wr_sof   (usr_tx_sof),
    .wr_eof   (usr_tx_eof),
    .wr_data  (usr_tx_data),
    .wr_ready (usr_tx_dst_rdy),
    .rd_valid (ch_tx_src_rdy),
    .rd_sof   (ch_tx_sof),
    .rd_eof   (ch_tx_eof),
    .rd_data  (ch_tx_data),
    .rd_pop   (ch_ren & ch_tx_dst_rdy),
    .drop_cnt (tx_drop_cnt)
  );

endmodule

// File: tb/tb_channel_endpoint.sv
// Directed bench for channel_endpoint with hand-computed expectations.
module tb_channel_endpoint;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       ch_rx_sof = 1'b0, ch_rx_eof = 1'b0, ch_rx_src_rdy = 1'b0;
  logic [7:0] ch_rx_data = '0;
  logic       ch_rx_dst_rdy;
  logic       ch_wen = 1'b0;
  logic       ch_tx_sof, ch_tx_eof, ch_tx_src_rdy;
  logic [7:0] ch_tx_data;
  logic       ch_tx_dst_rdy = 1'b0;
  logic       ch_ren = 1'b0;
  logic       usr_rx_sof, usr_rx_eof, usr_rx_src_rdy;
  logic [7:0] usr_rx_data;
  logic       usr_rx_dst_rdy = 1'b0;
  logic       usr_tx_sof = 1'b0, usr_tx_eof = 1'b0, usr_tx_src_rdy = 1'b0;
  logic [7:0] usr_tx_data = '0;
  logic       usr_tx_dst_rdy;
  logic [7:0] rx_drop_cnt, tx_drop_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  channel_endpoint #(.ADDR_W(4), .CH_ID(1)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .ch_rx_sof      (ch_rx_sof),
    .ch_rx_eof      (ch_rx_eof),
    .ch_rx_src_rdy  (ch_rx_src_rdy),
    .ch_rx_data     (ch_rx_data),
    .ch_rx_dst_rdy  (ch_rx_dst_rdy),
    .ch_wen         (ch_wen),
    .ch_tx_sof      (ch_tx_sof),
    .ch_tx_eof      (ch_tx_eof),
    .ch_tx_src_rdy  (ch_tx_src_rdy),
    .ch_tx_data     (ch_tx_data),
    .ch_tx_dst_rdy  (ch_tx_dst_rdy),
    .ch_ren         (ch_ren),
    .usr_rx_sof     (usr_rx_sof),
    .usr_rx_eof     (usr_rx_eof),
    .usr_rx_src_rdy (usr_rx_src_rdy),
    .usr_rx_data    (usr_rx_data),
    .usr_rx_dst_rdy (usr_rx_dst_rdy),
    .usr_tx_sof     (usr_tx_sof),
    .usr_tx_eof     (usr_tx_eof),
    .usr_tx_src_rdy (usr_tx_src_rdy),
    .usr_tx_data    (usr_tx_data),
    .usr_tx_dst_rdy (usr_tx_dst_rdy),
    .rx_drop_cnt    (rx_drop_cnt),
    .tx_drop_cnt    (tx_drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rx_beat(input logic sof, input logic eof, input logic [7:0] d);
    ch_rx_sof = sof;
    ch_rx_eof = eof;
    ch_rx_data = d;
    ch_rx_src_rdy = 1'b1;
    tick();
    ch_rx_src_rdy = 1'b0;
    ch_rx_sof = 1'b0;
    ch_rx_eof = 1'b0;
  endtask

  task automatic rx_read(input logic [7:0] base, input int len, input string tag);
    for (int i = 0; i < len; i++) begin
      chk({tag, "_vld"}, usr_rx_src_rdy, 1);
      chk({tag, "_data"}, usr_rx_data, 8'(base + i));
      chk({tag, "_sof"}, usr_rx_sof, (i == 0));
      chk({tag, "_eof"}, usr_rx_eof, (i == len - 1));
      usr_rx_dst_rdy = 1'b1;
      tick();
      usr_rx_dst_rdy = 1'b0;
    end
    chk({tag, "_drained"}, usr_rx_src_rdy, 0);
  endtask

  task automatic tx_push(input logic sof, input logic eof, input logic [7:0] d);
    int n;
    usr_tx_sof = sof;
    usr_tx_eof = eof;
    usr_tx_data = d;
    usr_tx_src_rdy = 1'b1;
    n = 0;
    while (!usr_tx_dst_rdy && n < 50) begin
      tick();
      n++;
    end
    if (n == 50) chk("tx_push_timeout", usr_tx_dst_rdy, 1);
    tick();
    usr_tx_src_rdy = 1'b0;
    usr_tx_sof = 1'b0;
    usr_tx_eof = 1'b0;
  endtask

  task automatic tx_read(input logic [7:0] base, input int len, input string tag);
    ch_ren = 1'b1;
    ch_tx_dst_rdy = 1'b1;
    for (int i = 0; i < len; i++) begin
      chk({tag, "_vld"}, ch_tx_src_rdy, 1);
      chk({tag, "_data"}, ch_tx_data, 8'(base + i));
      chk({tag, "_sof"}, ch_tx_sof, (i == 0));
      chk({tag, "_eof"}, ch_tx_eof, (i == len - 1));
      tick();
    end
    ch_ren = 1'b0;
    ch_tx_dst_rdy = 1'b0;
    chk({tag, "_drained"}, ch_tx_src_rdy, 0);
  endtask

  bit ren_pat [9] = '{1, 0, 0, 1, 1, 0, 1, 0, 1};
  bit dst_pat [9] = '{1, 1, 1, 0, 1, 1, 1, 0, 1};

  initial begin
    #400000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int  idx;
    logic ok;

    // reset values
    #3 rst_n = 1'b0;
    #20;
    chk("rst_usr_rx_vld", usr_rx_src_rdy, 0);
    chk("rst_ch_tx_vld", ch_tx_src_rdy, 0);
    chk("rst_ch_rx_rdy", ch_rx_dst_rdy, 0);
    chk("rst_usr_tx_rdy", usr_tx_dst_rdy, 0);
    chk("rst_rx_drop", rx_drop_cnt, 0);
    chk("rst_tx_drop", tx_drop_cnt, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    tick();
    tick();
    chk("rx_rdy_live", ch_rx_dst_rdy, 1);
    chk("tx_rdy_live", usr_tx_dst_rdy, 1);

    // basic rx frame and commit latency
    ch_wen = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (i == 4) chk("rx_no_early", usr_rx_src_rdy, 0);
      rx_beat(i == 0, i == 4, 8'(8'h11 + i));
    end
    chk("rx_commit_lat", usr_rx_src_rdy, 1);
    rx_read(8'h11, 5, "rx_basic");

    // wen filtering
    ch_wen = 1'b0;
    for (int i = 0; i < 5; i++) rx_beat(i == 0, i == 4, 8'(8'h11 + i));
    tick();
    chk("rx_wen_vld", usr_rx_src_rdy, 0);
    chk("rx_wen_drop", rx_drop_cnt, 0);

    // rx overflow, then a good frame
    ch_wen = 1'b1;
    for (int i = 0; i < 20; i++) rx_beat(i == 0, i == 19, 8'(8'h40 + i));
    chk("rx_ovf_drop", rx_drop_cnt, 1);
    chk("rx_ovf_vld", usr_rx_src_rdy, 0);
    chk("rx_ovf_rdy", ch_rx_dst_rdy, 1);
    for (int i = 0; i < 3; i++) rx_beat(i == 0, i == 2, 8'(8'hA1 + i));
    rx_read(8'hA1, 3, "rx_after_ovf");

    // truncation: sof without prior eof
    rx_beat(1, 0, 8'h31);
    rx_beat(0, 0, 8'h32);
    rx_beat(1, 0, 8'h51);
    rx_beat(0, 0, 8'h52);
    rx_beat(0, 1, 8'h53);
    chk("rx_trunc_drop", rx_drop_cnt, 2);
    rx_read(8'h51, 3, "rx_trunc");
    ch_wen = 1'b0;

    // tx ren gating
    for (int i = 0; i < 4; i++) tx_push(i == 0, i == 3, 8'(8'h21 + i));
    chk("tx_gate_avail", ch_tx_src_rdy, 1);
    idx = 0;
    for (int i = 0; i < 9; i++) begin
      chk("tx_gate_vld", ch_tx_src_rdy, 1);
      chk("tx_gate_data", ch_tx_data, 8'(8'h21 + idx));
      chk("tx_gate_sof", ch_tx_sof, (idx == 0));
      chk("tx_gate_eof", ch_tx_eof, (idx == 3));
      ch_ren = ren_pat[i];
      ch_tx_dst_rdy = dst_pat[i];
      tick();
      if (ren_pat[i] && dst_pat[i]) idx++;
    end
    ch_ren = 1'b0;
    ch_tx_dst_rdy = 1'b0;
    chk("tx_gate_empty", ch_tx_src_rdy, 0);

    // tx backpressure behind a pending committed frame
    tx_push(1, 0, 8'h61);
    tx_push(0, 1, 8'h62);
    for (int i = 0; i < 14; i++) tx_push(i == 0, 0, 8'(8'h70 + i));
    usr_tx_data = 8'h7E;
    usr_tx_src_rdy = 1'b1;
    chk("tx_bp_full", usr_tx_dst_rdy, 0);
    tick();
    chk("tx_bp_hold", usr_tx_dst_rdy, 0);
    ch_ren = 1'b1;
    ch_tx_dst_rdy = 1'b1;
    chk("tx_bp_head", ch_tx_data, 8'h61);
    tick();
    ch_ren = 1'b0;
    chk("tx_bp_release", usr_tx_dst_rdy, 1);
    tick();
    usr_tx_data = 8'h7F;
    usr_tx_eof = 1'b1;
    chk("tx_bp_full2", usr_tx_dst_rdy, 0);
    chk("tx_bp_head2", ch_tx_data, 8'h62);
    ch_ren = 1'b1;
    tick();
    ch_ren = 1'b0;
    chk("tx_bp_release2", usr_tx_dst_rdy, 1);
    tick();
    usr_tx_src_rdy = 1'b0;
    usr_tx_eof = 1'b0;
    tx_read(8'h70, 16, "tx_bp");

    // tx oversize frame into empty FIFO
    ok = 1'b1;
    for (int i = 0; i < 17; i++) begin
      if (!usr_tx_dst_rdy) ok = 1'b0;
      usr_tx_sof = (i == 0);
      usr_tx_eof = (i == 16);
      usr_tx_data = 8'(8'hC0 + i);
      usr_tx_src_rdy = 1'b1;
      tick();
    end
    usr_tx_src_rdy = 1'b0;
    usr_tx_sof = 1'b0;
    usr_tx_eof = 1'b0;
    chk("tx_ovs_rdy", ok, 1);
    chk("tx_ovs_drop", tx_drop_cnt, 1);
    chk("tx_ovs_vld", ch_tx_src_rdy, 0);
    tx_push(1, 1, 8'h91);
    tx_read(8'h91, 1, "tx_after_ovs");

    // reset mid-frame
    ch_wen = 1'b1;
    rx_beat(1, 1, 8'h01);
    tx_push(1, 1, 8'h02);
    rx_beat(1, 0, 8'h81);
    rx_beat(0, 0, 8'h82);
    chk("pre_rst_rx_vld", usr_rx_src_rdy, 1);
    chk("pre_rst_tx_vld", ch_tx_src_rdy, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_rx_vld", usr_rx_src_rdy, 0);
    chk("arst_tx_vld", ch_tx_src_rdy, 0);
    chk("arst_rx_rdy", ch_rx_dst_rdy, 0);
    chk("arst_tx_rdy", usr_tx_dst_rdy, 0);
    chk("arst_rx_drop", rx_drop_cnt, 0);
    chk("arst_tx_drop", tx_drop_cnt, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    tick();
    rx_beat(0, 1, 8'h83);
    tick();
    chk("post_rst_rx_vld", usr_rx_src_rdy, 0);
    chk("post_rst_tx_vld", ch_tx_src_rdy, 0);
    ch_wen = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
